// File: rtl/miriscv_data_arbiter.sv
// Two-master arbiter sharing one data-memory port; one access outstanding at a time.
// Round-robin (or fixed priority to master 0) with same-cycle regrant on the response cycle.
module miriscv_data_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1,
    parameter int FIXED_PRIO  = 0
) (
    input  logic                clk_i,
    input  logic                arstn_i,
    input  logic                m0_req_i,
    input  logic                m0_we_i,
    input  logic [DATA_W/8-1:0] m0_be_i,
    input  logic [ADDR_W-1:0]   m0_addr_i,
    input  logic [DATA_W-1:0]   m0_wdata_i,
    output logic                m0_gnt_o,
    output logic                m0_rvalid_o,
    output logic [DATA_W-1:0]   m0_rdata_o,
    input  logic                m1_req_i,
    input  logic                m1_we_i,
    input  logic [DATA_W/8-1:0] m1_be_i,
    input  logic [ADDR_W-1:0]   m1_addr_i,
    input  logic [DATA_W-1:0]   m1_wdata_i,
    output logic                m1_gnt_o,
    output logic                m1_rvalid_o,
    output logic [DATA_W-1:0]   m1_rdata_o,
    output logic                data_req_o,
    output logic                data_we_o,
    output logic [DATA_W/8-1:0] data_be_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    input  logic [DATA_W-1:0]   data_rdata_i,
    output logic                busy_o,
    output logic                owner_o
);
    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_bad_latency
        $error("miriscv_data_arbiter: MEM_LATENCY must be in 1..4");
    end

    localparam logic [2:0] LAT = 3'(MEM_LATENCY);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              owner_q, owner_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic resp, can_grant, win, grant;

    assign resp = (state_q == WAIT) && (cnt_q == LAT);
    // Grants are suppressed while reset is held so every output reads 0 during reset.
    assign can_grant = arstn_i && ((state_q == IDLE) || resp);

    always_comb begin
        win = ~m0_req_i;
        if (m0_req_i && m1_req_i) begin
            win = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant_q;
        end
    end

    assign m0_gnt_o = can_grant && m0_req_i && !win;
    assign m1_gnt_o = can_grant && m1_req_i && win;
    assign grant    = m0_gnt_o || m1_gnt_o;

    always_comb begin
        data_req_o   = grant;
        data_we_o    = 1'b0;
        data_be_o    = '0;
        data_addr_o  = '0;
        data_wdata_o = '0;
        if (m0_gnt_o) begin
            data_we_o    = m0_we_i;
            data_be_o    = m0_be_i;
            data_addr_o  = m0_addr_i;
            data_wdata_o = m0_wdata_i;
        end else if (m1_gnt_o) begin
            data_we_o    = m1_we_i;
            data_be_o    = m1_be_i;
            data_addr_o  = m1_addr_i;
            data_wdata_o = m1_wdata_i;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        we_d         = we_q;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    state_d = WAIT;
                    cnt_d   = 3'd1;
                end
            end
            WAIT: begin
                if (resp) begin
                    if (grant) begin
                        cnt_d = 3'd1;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 3'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        if (grant) begin
            last_grant_d = m1_gnt_o;
            owner_d      = m1_gnt_o;
            we_d         = data_we_o;
        end
        if (resp && !we_q) begin
            if (owner_q) rdata1_d = data_rdata_i;
            else         rdata0_d = data_rdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    // Read data is forwarded live on the response cycle, then the registered copy is held.
    assign m0_rvalid_o = resp && !owner_q;
    assign m1_rvalid_o = resp && owner_q;
    assign m0_rdata_o  = (m0_rvalid_o && !we_q) ? data_rdata_i : rdata0_q;
    assign m1_rdata_o  = (m1_rvalid_o && !we_q) ? data_rdata_i : rdata1_q;
    assign busy_o      = (state_q == WAIT);
    assign owner_o     = owner_q;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Bench for miriscv_data_arbiter: instance 0 is MEM_LATENCY=1 round-robin,
// instance 1 is MEM_LATENCY=3 fixed priority; both are checked against a cycle-level model.
module tb_miriscv_data_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          arstn [2];
    logic          req   [2][2];
    logic          we    [2][2];
    logic [BW-1:0] be    [2][2];
    logic [AW-1:0] addr  [2][2];
    logic [DW-1:0] wdata [2][2];
    logic          gnt   [2][2];
    logic          rvalid[2][2];
    logic [DW-1:0] rdata [2][2];
    logic          d_req [2];
    logic          d_we  [2];
    logic [BW-1:0] d_be  [2];
    logic [AW-1:0] d_addr[2];
    logic [DW-1:0] d_wdata[2];
    logic [DW-1:0] d_rdata[2];
    logic          busy  [2];
    logic          owner [2];

    miriscv_data_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(1), .FIXED_PRIO(0)) u_rr (
        .clk_i(clk), .arstn_i(arstn[0]),
        .m0_req_i(req[0][0]), .m0_we_i(we[0][0]), .m0_be_i(be[0][0]), .m0_addr_i(addr[0][0]),
        .m0_wdata_i(wdata[0][0]), .m0_gnt_o(gnt[0][0]), .m0_rvalid_o(rvalid[0][0]), .m0_rdata_o(rdata[0][0]),
        .m1_req_i(req[0][1]), .m1_we_i(we[0][1]), .m1_be_i(be[0][1]), .m1_addr_i(addr[0][1]),
        .m1_wdata_i(wdata[0][1]), .m1_gnt_o(gnt[0][1]), .m1_rvalid_o(rvalid[0][1]), .m1_rdata_o(rdata[0][1]),
        .data_req_o(d_req[0]), .data_we_o(d_we[0]), .data_be_o(d_be[0]), .data_addr_o(d_addr[0]),
        .data_wdata_o(d_wdata[0]), .data_rdata_i(d_rdata[0]), .busy_o(busy[0]), .owner_o(owner[0])
    );

    miriscv_data_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(3), .FIXED_PRIO(1)) u_fp (
        .clk_i(clk), .arstn_i(arstn[1]),
        .m0_req_i(req[1][0]), .m0_we_i(we[1][0]), .m0_be_i(be[1][0]), .m0_addr_i(addr[1][0]),
        .m0_wdata_i(wdata[1][0]), .m0_gnt_o(gnt[1][0]), .m0_rvalid_o(rvalid[1][0]), .m0_rdata_o(rdata[1][0]),
        .m1_req_i(req[1][1]), .m1_we_i(we[1][1]), .m1_be_i(be[1][1]), .m1_addr_i(addr[1][1]),
        .m1_wdata_i(wdata[1][1]), .m1_gnt_o(gnt[1][1]), .m1_rvalid_o(rvalid[1][1]), .m1_rdata_o(rdata[1][1]),
        .data_req_o(d_req[1]), .data_we_o(d_we[1]), .data_be_o(d_be[1]), .data_addr_o(d_addr[1]),
        .data_wdata_o(d_wdata[1]), .data_rdata_i(d_rdata[1]), .busy_o(busy[1]), .owner_o(owner[1])
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: one outstanding access, tracked by its due cycle.
    logic          mb_busy [2];
    logic          mb_owner[2];
    logic          mb_we   [2];
    logic          mb_last [2];
    int            mb_due  [2];
    int            mb_cyc  [2];
    logic [DW-1:0] mb_held [2][2];
    logic [DW-1:0] exp_q   [2][$];

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic fp_of(input int k);
        return (k == 1);
    endfunction

    // The memory returns a fixed function of the address (0x100 -> 0xDEADBEEF).
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        return a ^ 32'hDEADBFEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic clear_inputs(input int k);
        for (int m = 0; m < 2; m++) begin
            req[k][m] = 1'b0; we[k][m] = 1'b0; be[k][m] = '0; addr[k][m] = '0; wdata[k][m] = '0;
        end
    endtask

    task automatic model_reset(input int k);
        mb_busy[k] = 1'b0; mb_owner[k] = 1'b0; mb_we[k] = 1'b0; mb_last[k] = 1'b1;
        mb_due[k] = 0; mb_cyc[k] = 0;
        mb_held[k][0] = '0; mb_held[k][1] = '0;
        exp_q[k].delete();
    endtask

    task automatic chk_zero(input int k, input string tag);
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("%s k%0d m%0d gnt", tag, k, m), 32'(gnt[k][m]), 32'd0);
            chk($sformatf("%s k%0d m%0d rvalid", tag, k, m), 32'(rvalid[k][m]), 32'd0);
            chk($sformatf("%s k%0d m%0d rdata", tag, k, m), rdata[k][m], 32'd0);
        end
        chk($sformatf("%s k%0d data_req", tag, k), 32'(d_req[k]), 32'd0);
        chk($sformatf("%s k%0d data_we", tag, k), 32'(d_we[k]), 32'd0);
        chk($sformatf("%s k%0d data_be", tag, k), 32'(d_be[k]), 32'd0);
        chk($sformatf("%s k%0d data_addr", tag, k), d_addr[k], 32'd0);
        chk($sformatf("%s k%0d data_wdata", tag, k), d_wdata[k], 32'd0);
        chk($sformatf("%s k%0d busy", tag, k), 32'(busy[k]), 32'd0);
        chk($sformatf("%s k%0d owner", tag, k), 32'(owner[k]), 32'd0);
    endtask

    // Called just after a falling edge with inputs already driven; does not advance the clock.
    task automatic step(input int k, output int w);
        logic          resp;
        logic [DW-1:0] rsp_data;
        logic [DW-1:0] exp_rd;
        resp     = mb_busy[k] && (mb_cyc[k] == mb_due[k]);
        rsp_data = (exp_q[k].size() > 0) ? exp_q[k][0] : '0;
        d_rdata[k] = (resp && !mb_we[k]) ? rsp_data : $urandom();
        w = -1;
        if (!mb_busy[k] || resp) begin
            if (req[k][0] && req[k][1]) w = fp_of(k) ? 0 : (mb_last[k] ? 0 : 1);
            else if (req[k][0])         w = 0;
            else if (req[k][1])         w = 1;
        end
        #1;
        for (int m = 0; m < 2; m++) begin
            exp_rd = (resp && !mb_we[k] && (mb_owner[k] == m[0])) ? rsp_data : mb_held[k][m];
            chk($sformatf("k%0d m%0d gnt", k, m), 32'(gnt[k][m]), 32'(w == m));
            chk($sformatf("k%0d m%0d rvalid", k, m), 32'(rvalid[k][m]), 32'(resp && (mb_owner[k] == m[0])));
            chk($sformatf("k%0d m%0d rdata", k, m), rdata[k][m], exp_rd);
        end
        chk($sformatf("k%0d data_req", k), 32'(d_req[k]), 32'(w >= 0));
        chk($sformatf("k%0d data_we", k), 32'(d_we[k]), (w >= 0) ? 32'(we[k][w]) : 32'd0);
        chk($sformatf("k%0d data_be", k), 32'(d_be[k]), (w >= 0) ? 32'(be[k][w]) : 32'd0);
        chk($sformatf("k%0d data_addr", k), d_addr[k], (w >= 0) ? addr[k][w] : 32'd0);
        chk($sformatf("k%0d data_wdata", k), d_wdata[k], (w >= 0) ? wdata[k][w] : 32'd0);
        chk($sformatf("k%0d busy", k), 32'(busy[k]), 32'(mb_busy[k]));
        if (mb_busy[k]) chk($sformatf("k%0d owner", k), 32'(owner[k]), 32'(mb_owner[k]));
        if (resp) begin
            if (!mb_we[k]) mb_held[k][mb_owner[k]] = rsp_data;
            void'(exp_q[k].pop_front());
            mb_busy[k] = 1'b0;
        end
        if (w >= 0) begin
            mb_busy[k]  = 1'b1;
            mb_owner[k] = w[0];
            mb_last[k]  = w[0];
            mb_we[k]    = we[k][w];
            mb_due[k]   = mb_cyc[k] + lat_of(k);
            exp_q[k].push_back(we[k][w] ? wdata[k][w] : mem_f(addr[k][w]));
        end
        mb_cyc[k]++;
    endtask

    task automatic tick(input int k);
        int w;
        step(k, w);
        @(negedge clk);
    endtask

    task automatic do_reset(input int k);
        arstn[k] = 1'b0;
        clear_inputs(k);
        #1;
        chk_zero(k, "reset");
        arstn[k] = 1'b1;
        model_reset(k);
        @(negedge clk);
    endtask

    task automatic run_random(input int k, input int n);
        logic pend[2];
        int   w;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int c = 0; c < n; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m]) begin
                    pend[m]     = ($urandom_range(0, 2) != 0);
                    we[k][m]    = $urandom_range(0, 1) == 1;
                    be[k][m]    = 4'($urandom_range(0, 15));
                    addr[k][m]  = $urandom() & 32'hFFFF_FFFC;
                    wdata[k][m] = $urandom();
                end
                req[k][m] = pend[m];
            end
            step(k, w);
            if (w >= 0) pend[w] = 1'b0;
            @(negedge clk);
        end
        clear_inputs(k);
        repeat (5) tick(k);
    endtask

    typedef struct {
        logic [1:0]    req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [1:0]    gnt;
        logic [1:0]    rv;
        logic [AW-1:0] addr;
        logic [DW-1:0] rd0;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int   w;
        vec_t v;
        logic [AW-1:0] na[2];

        tbl[0] = '{2'b00, 32'h000, 32'h000, 2'b00, 2'b00, 32'h000, 32'h0};
        tbl[1] = '{2'b01, 32'h100, 32'h000, 2'b01, 2'b00, 32'h100, 32'h0};
        tbl[2] = '{2'b00, 32'h000, 32'h000, 2'b00, 2'b01, 32'h000, 32'hDEADBEEF};
        tbl[3] = '{2'b11, 32'h200, 32'h300, 2'b10, 2'b00, 32'h300, 32'hDEADBEEF};
        tbl[4] = '{2'b11, 32'h200, 32'h340, 2'b01, 2'b10, 32'h200, 32'hDEADBEEF};
        tbl[5] = '{2'b10, 32'h000, 32'h340, 2'b10, 2'b01, 32'h340, 32'hDEADBDEF};
        tbl[6] = '{2'b11, 32'h400, 32'h380, 2'b01, 2'b10, 32'h400, 32'hDEADBDEF};
        tbl[7] = '{2'b00, 32'h000, 32'h000, 2'b00, 2'b01, 32'h000, 32'hDEADBBEF};
        tbl[8] = '{2'b00, 32'h000, 32'h000, 2'b00, 2'b00, 32'h000, 32'hDEADBBEF};

        for (int k = 0; k < 2; k++) begin
            arstn[k] = 1'b0; clear_inputs(k); model_reset(k); d_rdata[k] = '0;
        end
        repeat (2) @(negedge clk);
        // Requests present during reset must not be granted.
        req[0][0] = 1'b1; req[1][1] = 1'b1; addr[0][0] = 32'h44;
        #1;
        chk_zero(0, "in_reset");
        chk_zero(1, "in_reset");
        clear_inputs(0); clear_inputs(1);
        arstn[0] = 1'b1; arstn[1] = 1'b1;
        @(negedge clk);

        // Table: single and contended accesses at latency 1, round-robin.
        for (int i = 0; i < 9; i++) begin
            v = tbl[i];
            req[0][0] = v.req[0]; req[0][1] = v.req[1];
            addr[0][0] = v.a0; addr[0][1] = v.a1;
            we[0][0] = 1'b0; we[0][1] = (i == 5);
            be[0][0] = 4'hF; be[0][1] = 4'h0;
            wdata[0][0] = $urandom(); wdata[0][1] = $urandom();
            step(0, w);
            chk($sformatf("tbl%0d gnt", i), 32'({gnt[0][1], gnt[0][0]}), 32'(v.gnt));
            chk($sformatf("tbl%0d rvalid", i), 32'({rvalid[0][1], rvalid[0][0]}), 32'(v.rv));
            chk($sformatf("tbl%0d addr", i), d_addr[0], v.addr);
            chk($sformatf("tbl%0d rdata0", i), rdata[0][0], v.rd0);
            @(negedge clk);
        end

        // Both masters request from reset: strict alternation starting with m0, back-to-back.
        do_reset(0);
        na[0] = 32'h1000; na[1] = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            req[0][0] = 1'b1; req[0][1] = 1'b1;
            addr[0][0] = na[0]; addr[0][1] = na[1];
            step(0, w);
            chk($sformatf("rr%0d gnt_win", i), 32'(gnt[0][i % 2]), 32'd1);
            chk($sformatf("rr%0d gnt_lose", i), 32'(gnt[0][1 - (i % 2)]), 32'd0);
            chk($sformatf("rr%0d data_req", i), 32'(d_req[0]), 32'd1);
            chk($sformatf("rr%0d addr", i), d_addr[0], na[i % 2]);
            na[i % 2] = na[i % 2] + 32'd4;
            @(negedge clk);
        end
        clear_inputs(0);
        repeat (2) tick(0);

        // Fixed priority, latency 3: m0 re-requests continuously and m1 starves.
        do_reset(1);
        na[0] = 32'h3000;
        for (int i = 0; i < 12; i++) begin
            req[1][0] = 1'b1; req[1][1] = 1'b1;
            addr[1][0] = na[0]; addr[1][1] = 32'h4000;
            step(1, w);
            chk($sformatf("fp%0d m1_gnt", i), 32'(gnt[1][1]), 32'd0);
            chk($sformatf("fp%0d m0_gnt", i), 32'(gnt[1][0]), 32'((i % 3) == 0));
            if ((i % 3) == 0) na[0] = na[0] + 32'd4;
            @(negedge clk);
        end
        req[1][0] = 1'b0;
        step(1, w);
        chk("fp m1_gnt_after_drop", 32'(gnt[1][1]), 32'd1);
        @(negedge clk);
        clear_inputs(1);
        repeat (4) tick(1);

        // Latency 3: m1 write with partial byte enables, m0 arrives one cycle later.
        do_reset(1);
        req[1][1] = 1'b1; we[1][1] = 1'b1; be[1][1] = 4'b0011;
        addr[1][1] = 32'h50; wdata[1][1] = 32'h1234_5678;
        step(1, w);
        chk("wr gnt1", 32'(gnt[1][1]), 32'd1);
        chk("wr data_we", 32'(d_we[1]), 32'd1);
        chk("wr data_be", 32'(d_be[1]), 32'b0011);
        @(negedge clk);
        req[1][1] = 1'b0; we[1][1] = 1'b0; be[1][1] = '0;
        req[1][0] = 1'b1; addr[1][0] = 32'h60; be[1][0] = 4'hF;
        for (int i = 1; i < 3; i++) begin
            step(1, w);
            chk($sformatf("wr t%0d m0_gnt", i), 32'(gnt[1][0]), 32'd0);
            chk($sformatf("wr t%0d m0_rvalid", i), 32'(rvalid[1][0]), 32'd0);
            chk($sformatf("wr t%0d busy", i), 32'(busy[1]), 32'd1);
            @(negedge clk);
        end
        step(1, w);
        chk("wr t3 m1_rvalid", 32'(rvalid[1][1]), 32'd1);
        chk("wr t3 m0_rvalid", 32'(rvalid[1][0]), 32'd0);
        chk("wr t3 m0_gnt", 32'(gnt[1][0]), 32'd1);
        @(negedge clk);
        req[1][0] = 1'b0; addr[1][0] = 32'hFFFF_0000;
        repeat (2) tick(1);
        step(1, w);
        chk("rd t6 m0_rvalid", 32'(rvalid[1][0]), 32'd1);
        chk("rd t6 m0_rdata", rdata[1][0], 32'h60 ^ 32'hDEADBFEF);
        @(negedge clk);
        repeat (2) tick(1);

        // Reset in the middle of an access: no late response afterwards.
        do_reset(1);
        req[1][0] = 1'b1; addr[1][0] = 32'h70;
        tick(1);
        addr[1][0] = 32'h74;
        arstn[1] = 1'b0;
        #1;
        chk_zero(1, "mid_reset");
        clear_inputs(1);
        arstn[1] = 1'b1;
        model_reset(1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            step(1, w);
            chk($sformatf("post_rst%0d m0_rvalid", i), 32'(rvalid[1][0]), 32'd0);
            @(negedge clk);
        end

        run_random(0, 600);
        run_random(1, 600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
